add_sub_accum: RTL and testbench

Downstream consumer of the add_sub stream stage. It takes 128-bit beats, each holding four packed 32-bit lanes, and sums a fixed number of beats lane-wise. It then emits one 128-bit result beat per transaction. Control uses the same ap_ctrl_hs style as the rest of the kernel chain: ap_start begins a transaction, and ap_done/ap_ready pulse on completion.

---
 rtl/add_sub_accum.sv | 126 ++++++++++++
 tb/tb_add_sub_accum.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_accum.sv
// add_sub_accum
// Lane-wise accumulator sitting after the add_sub stream stage. Each
// transaction sums `count` input beats (LANES packed lanes of LANE_W bits,
// modulo 2^LANE_W per lane) and emits one result beat. Control follows the
// ap_ctrl_hs handshake used elsewhere in the kernel chain.
//
// Ports
//   ap_clk, ap_rst_n          clock, synchronous active-low reset
//   ap_start                  start request (level), sampled in IDLE only
//   ap_done, ap_ready         one-cycle pulse on the output handshake
//   ap_idle                   IDLE and no start pending
//   count                     beats per transaction, latched when leaving IDLE
//   axis_in_TDATA/TVALID/TREADY     input beat stream
//   axis_out_TDATA/TVALID/TREADY    result beat stream
//
// state  | meaning
// IDLE   | waiting for ap_start; no stream handshakes
// ACCUM  | accepting input beats and summing lane-wise
// EMIT   | presenting the result until downstream takes it
module add_sub_accum #(
  parameter int LANE_W = 32,
  parameter int LANES  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      ap_start,
  output logic                      ap_done,
  output logic                      ap_idle,
  output logic                      ap_ready,
  input  logic [CNT_W-1:0]          count,
  input  logic [LANE_W*LANES-1:0]   axis_in_TDATA,
  input  logic                      axis_in_TVALID,
  output logic                      axis_in_TREADY,
  output logic [LANE_W*LANES-1:0]   axis_out_TDATA,
  output logic                      axis_out_TVALID,
  input  logic                      axis_out_TREADY
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_EMIT  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [LANE_W-1:0] acc_q [LANES];
  logic [CNT_W-1:0]  beat_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              in_hs;
  logic              last_beat;

  assign in_hs = axis_in_TVALID && (state_q == S_ACCUM);

  // Compare against cnt_q-1 rather than letting beat_q reach cnt_q, so that
  // the maximum count never needs a value the counter cannot hold.
  assign last_beat = (beat_q == (cnt_q - CNT_W'(1)));

  for (genvar k = 0; k < LANES; k++) begin : g_pack
    assign axis_out_TDATA[k*LANE_W +: LANE_W] = acc_q[k];
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      cnt_q   <= '0;
      for (int k = 0; k < LANES; k++) acc_q[k] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (ap_start) begin
            cnt_q  <= count;
            beat_q <= '0;
            for (int k = 0; k < LANES; k++) acc_q[k] <= '0;
          end
        end
        S_ACCUM: begin
          if (in_hs) begin
            beat_q <= beat_q + CNT_W'(1);
            for (int k = 0; k < LANES; k++)
              acc_q[k] <= acc_q[k] + axis_in_TDATA[k*LANE_W +: LANE_W];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d         = state_q;
    axis_in_TREADY  = 1'b0;
    axis_out_TVALID = 1'b0;
    ap_done         = 1'b0;
    ap_ready        = 1'b0;
    ap_idle         = 1'b0;
    case (state_q)
      S_IDLE: begin
        ap_idle = !ap_start;
        if (ap_start) begin
          state_d = (count != '0) ? S_ACCUM : S_EMIT;
        end
      end
      S_ACCUM: begin
        axis_in_TREADY = 1'b1;
        if (in_hs && last_beat) begin
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        axis_out_TVALID = 1'b1;
        if (axis_out_TREADY) begin
          ap_done  = 1'b1;
          ap_ready = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_add_sub_accum.sv
module tb_add_sub_accum;

  logic         ap_clk;
  logic         ap_rst_n;
  logic         ap_start;
  logic         ap_done;
  logic         ap_idle;
  logic         ap_ready;
  logic [15:0]  count;
  logic [127:0] axis_in_TDATA;
  logic         axis_in_TVALID;
  logic         axis_in_TREADY;
  logic [127:0] axis_out_TDATA;
  logic         axis_out_TVALID;
  logic         axis_out_TREADY;

  int checks = 0;
  int errors = 0;
  logic [127:0] beats [$];

  add_sub_accum dut (
    .ap_clk          (ap_clk),
    .ap_rst_n        (ap_rst_n),
    .ap_start        (ap_start),
    .ap_done         (ap_done),
    .ap_idle         (ap_idle),
    .ap_ready        (ap_ready),
    .count           (count),
    .axis_in_TDATA   (axis_in_TDATA),
    .axis_in_TVALID  (axis_in_TVALID),
    .axis_in_TREADY  (axis_in_TREADY),
    .axis_out_TDATA  (axis_out_TDATA),
    .axis_out_TVALID (axis_out_TVALID),
    .axis_out_TREADY (axis_out_TREADY)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  function automatic logic [127:0] mk(input logic [31:0] l0, input logic [31:0] l1,
                                      input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference: each result lane is the plain 32-bit (wrapping) sum of that
  // lane over all beats of the transaction.
  function automatic logic [127:0] ref_sum();
    logic [31:0] lane [4];
    logic [127:0] b;
    for (int k = 0; k < 4; k++) lane[k] = 32'h0;
    foreach (beats[i]) begin
      b = beats[i];
      for (int k = 0; k < 4; k++) lane[k] = lane[k] + b[k*32 +: 32];
    end
    return {lane[3], lane[2], lane[1], lane[0]};
  endfunction

  // Starts in IDLE, 2ns after a rising edge. Feeds the queued beats, holds
  // back the result for bp cycles, checks the result and handshake, and
  // returns one cycle after the done pulse (back in IDLE).
  task automatic run_txn(input int n, input bit stall, input int bp, input bit hold,
                         input bit check_each);
    logic [127:0] exp_d;
    int idx, cyc, last_hs, limit;
    bit tog, timed_out;
    exp_d = ref_sum();
    ap_start = 1'b1;
    count = 16'(n);
    axis_in_TVALID = 1'b1;
    axis_in_TDATA = rnd128();
    #1;
    chk("idle_in_ready", axis_in_TREADY, 1'b0);
    chk("idle_flag", ap_idle, 1'b0);
    chk("idle_out_valid", axis_out_TVALID, 1'b0);
    step();
    if (!hold) ap_start = 1'b0;
    idx = 0; cyc = 0; last_hs = -1; tog = 1'b1; timed_out = 1'b0;
    limit = n * 3 + 10;
    forever begin
      count = 16'($urandom());
      if (idx < n && (!stall || tog)) begin
        axis_in_TVALID = 1'b1;
        axis_in_TDATA = beats[idx];
      end else begin
        axis_in_TVALID = 1'b0;
        axis_in_TDATA = rnd128();
      end
      #1;
      if (axis_out_TVALID) break;
      if (check_each || cyc == 0) begin
        chk("accum_ready", axis_in_TREADY, 1'b1);
        chk("accum_done", ap_done, 1'b0);
      end
      if (axis_in_TVALID && axis_in_TREADY) begin
        idx++;
        last_hs = cyc;
      end
      tog = !tog;
      cyc++;
      if (cyc > limit) begin
        timed_out = 1'b1;
        break;
      end
      step();
    end
    axis_in_TVALID = 1'b0;
    if (timed_out) begin
      chk("timeout_out_valid", axis_out_TVALID, 1'b1);
      return;
    end
    chk("beats_consumed", 128'(idx), 128'(n));
    if (n > 0) chk("valid_latency", 128'(cyc - last_hs), 128'd1);
    if (!stall) chk("accum_cycles", 128'(cyc), 128'(n));
    chk("emit_in_ready", axis_in_TREADY, 1'b0);
    for (int b = 0; b < bp; b++) begin
      axis_out_TREADY = 1'b0;
      if (!hold) ap_start = $urandom_range(0, 1) != 0;
      #1;
      chk("bp_valid", axis_out_TVALID, 1'b1);
      chk("bp_data", axis_out_TDATA, exp_d);
      chk("bp_done", ap_done, 1'b0);
      step();
    end
    if (!hold) ap_start = 1'b0;
    axis_out_TREADY = 1'b1;
    #1;
    chk("out_valid", axis_out_TVALID, 1'b1);
    chk("out_data", axis_out_TDATA, exp_d);
    chk("out_done", ap_done, 1'b1);
    chk("out_ready", ap_ready, 1'b1);
    step();
    axis_out_TREADY = 1'b0;
    #1;
    chk("post_valid", axis_out_TVALID, 1'b0);
    chk("post_done", ap_done, 1'b0);
  endtask

  initial begin
    ap_rst_n = 1'b0;
    ap_start = 1'b0;
    count = 16'd0;
    axis_in_TDATA = '0;
    axis_in_TVALID = 1'b0;
    axis_out_TREADY = 1'b0;
    step();
    step();
    chk("rst_in_ready", axis_in_TREADY, 1'b0);
    chk("rst_out_valid", axis_out_TVALID, 1'b0);
    chk("rst_done", ap_done, 1'b0);
    chk("rst_ready", ap_ready, 1'b0);
    chk("rst_idle", ap_idle, 1'b1);
    ap_rst_n = 1'b1;
    step();
    chk("idle_no_start", ap_idle, 1'b1);

    // Basic: three beats of {1,2,3,4}.
    beats = {mk(1, 2, 3, 4), mk(1, 2, 3, 4), mk(1, 2, 3, 4)};
    run_txn(3, 1'b0, 0, 1'b0, 1'b1);

    // Lane wrap, no carry between lanes.
    beats = {mk(32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000),
             mk(32'h0000_0002, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000)};
    run_txn(2, 1'b0, 0, 1'b0, 1'b1);
    chk("wrap_const", ref_sum(), mk(1, 0, 0, 0));

    // Input stalls and output backpressure.
    beats.delete();
    for (int i = 0; i < 4; i++) beats.push_back(rnd128());
    run_txn(4, 1'b1, 5, 1'b0, 1'b1);

    // Zero-length transaction.
    beats.delete();
    run_txn(0, 1'b0, 0, 1'b0, 1'b1);

    // Reset in the middle of accumulation.
    ap_start = 1'b1;
    count = 16'd4;
    step();
    ap_start = 1'b0;
    axis_in_TVALID = 1'b1;
    axis_in_TDATA = rnd128();
    step();
    axis_in_TDATA = rnd128();
    step();
    ap_rst_n = 1'b0;
    axis_in_TVALID = 1'b0;
    step();
    chk("midrst_in_ready", axis_in_TREADY, 1'b0);
    chk("midrst_out_valid", axis_out_TVALID, 1'b0);
    chk("midrst_idle", ap_idle, 1'b1);
    ap_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("postrst_out_valid", axis_out_TVALID, 1'b0);
    end
    beats = {mk(5, 6, 7, 8)};
    run_txn(1, 1'b0, 0, 1'b0, 1'b1);

    // Back-to-back with ap_start held high.
    beats = {mk(1, 1, 1, 1)};
    run_txn(1, 1'b0, 0, 1'b1, 1'b1);
    beats = {mk(2, 2, 2, 2)};
    run_txn(1, 1'b0, 0, 1'b1, 1'b1);
    ap_start = 1'b0;
    #1;
    chk("b2b_end_idle", ap_idle, 1'b1);

    // Randomized transactions.
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 7);
      beats.delete();
      for (int i = 0; i < n; i++) beats.push_back(rnd128());
      run_txn(n, $urandom_range(0, 1) != 0, $urandom_range(0, 3), 1'b0, 1'b1);
    end

    // Largest count: the beat counter must reach the terminal compare.
    beats.delete();
    for (int i = 0; i < 65535; i++) beats.push_back(rnd128());
    run_txn(65535, 1'b0, 1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
